// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the systolic array blocks (core, feeder, result
// drain): array geometry, lane/index/mask types and the drain FSM states.
// ---------------------------------------------------------------------------
package sa_pkg;

    localparam int ROWS = 8;
    localparam int DW   = 32;

    typedef logic [DW-1:0]            result_t;
    typedef logic [$clog2(ROWS)-1:0]  row_idx_t;
    typedef logic [ROWS-1:0]          row_mask_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        DRAIN = 2'd2
    } drain_state_t;

endpackage

// File: rtl/sa_lsb_enc.sv
// ---------------------------------------------------------------------------
// sa_lsb_enc
// Combinational lowest-set-bit encoder for a row mask.
// Ports:
//   mask   - input row mask, bit i = row i
//   idx    - index of the lowest set bit (0 when mask is empty)
//   onehot - exactly one bit of mask is set
//   any    - at least one bit of mask is set
// ---------------------------------------------------------------------------
module sa_lsb_enc #(
    parameter int ROWS = sa_pkg::ROWS,
    localparam int IDXW = $clog2(ROWS)
) (
    input  logic [ROWS-1:0] mask,
    output logic [IDXW-1:0] idx,
    output logic            onehot,
    output logic            any
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDXW'(i);
            end
        end
    end

    assign any    = |mask;
    // Clearing the lowest set bit leaves zero only when a single bit was set.
    assign onehot = any && ((mask & (mask - ROWS'(1))) == '0);

endmodule

// File: rtl/sa_result_drain.sv
// ---------------------------------------------------------------------------
// sa_result_drain
// Consumer end of the systolic core's result interface. Snapshots the
// per-row results when any row valid is seen, acknowledges the snapshot
// with a one-cycle outread pulse, then serialises the valid rows (lowest
// row first) onto a valid/ready stream.
// Ports:
//   clk, rstn        - clock, asynchronous active-low reset
//   routport         - per-row results from the core (ROWS x DW)
//   rvalidport       - per-row result valids, bit i = row i
//   outread          - one-cycle acknowledge to the core
//   m_data/m_row     - serialised result and its row index
//   m_last           - final beat of the current snapshot
//   m_valid/m_ready  - stream handshake
//   busy             - FSM is not in IDLE
//   results_total    - accepted beat count, wraps silently
// ---------------------------------------------------------------------------
module sa_result_drain
    import sa_pkg::*;
#(
    parameter int ROWS = sa_pkg::ROWS,
    parameter int DW   = sa_pkg::DW,
    parameter int CNTW = 16,
    localparam int IDXW = $clog2(ROWS)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [ROWS-1:0][DW-1:0]  routport,
    input  logic [ROWS-1:0]          rvalidport,
    output logic                     outread,
    output logic [DW-1:0]            m_data,
    output logic [IDXW-1:0]          m_row,
    output logic                     m_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     busy,
    output logic [CNTW-1:0]          results_total
);

    drain_state_t             state_q, state_d;
    logic [ROWS-1:0][DW-1:0]  snap_q, snap_d;
    logic [ROWS-1:0]          mask_q, mask_d;
    logic                     outread_q, outread_d;
    logic                     m_valid_q, m_valid_d;
    logic [DW-1:0]            m_data_q, m_data_d;
    logic [IDXW-1:0]          m_row_q, m_row_d;
    logic                     m_last_q, m_last_d;
    logic [CNTW-1:0]          cnt_q, cnt_d;

    logic [ROWS-1:0]          mask_cleared;
    logic [ROWS-1:0]          enc_mask;
    logic [IDXW-1:0]          enc_idx;
    logic                     enc_onehot;
    logic                     enc_any;
    logic                     accept;

    assign accept       = m_valid_q && m_ready;
    // Mask with the currently presented row removed.
    assign mask_cleared = mask_q & ~(ROWS'(1) << m_row_q);
    // In ACK the encoder looks at the fresh snapshot mask; in DRAIN it looks
    // ahead at the mask as it will be after the current beat is accepted, so
    // the next beat can be registered in the same cycle.
    assign enc_mask     = (state_q == DRAIN) ? mask_cleared : mask_q;

    sa_lsb_enc #(
        .ROWS (ROWS)
    ) u_lsb_enc (
        .mask   (enc_mask),
        .idx    (enc_idx),
        .onehot (enc_onehot),
        .any    (enc_any)
    );

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        mask_d    = mask_q;
        outread_d = 1'b0;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_row_d   = m_row_q;
        m_last_d  = m_last_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                // Inputs are only ever sampled here; the core holds them
                // stable until it sees the acknowledge.
                if (|rvalidport) begin
                    snap_d    = routport;
                    mask_d    = rvalidport;
                    outread_d = 1'b1;
                    state_d   = ACK;
                end
            end

            ACK: begin
                m_valid_d = enc_any;
                m_row_d   = enc_idx;
                m_data_d  = snap_q[enc_idx];
                m_last_d  = enc_onehot;
                state_d   = DRAIN;
            end

            DRAIN: begin
                if (accept) begin
                    mask_d = mask_cleared;
                    cnt_d  = cnt_q + CNTW'(1);
                    if (m_last_q) begin
                        m_valid_d = 1'b0;
                        m_data_d  = '0;
                        m_row_d   = '0;
                        m_last_d  = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        m_row_d   = enc_idx;
                        m_data_d  = snap_q[enc_idx];
                        m_last_d  = enc_onehot;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                m_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            mask_q    <= '0;
            outread_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_row_q   <= '0;
            m_last_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            mask_q    <= mask_d;
            outread_q <= outread_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_row_q   <= m_row_d;
            m_last_q  <= m_last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign outread       = outread_q;
    assign m_valid       = m_valid_q;
    assign m_data        = m_data_q;
    assign m_row         = m_row_q;
    assign m_last        = m_last_q;
    assign busy          = (state_q != IDLE);
    assign results_total = cnt_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// ---------------------------------------------------------------------------
// tb_sa_result_drain
// Self-checking bench for sa_result_drain. A second instance with a 4-bit
// counter shares all inputs so counter wrap can be observed alongside the
// 16-bit instance.
// ---------------------------------------------------------------------------
module tb_sa_result_drain;
    import sa_pkg::*;

    localparam int IDXW = $clog2(ROWS);

    logic                     clk = 1'b0;
    logic                     rstn;
    logic [ROWS-1:0][DW-1:0]  routport;
    logic [ROWS-1:0]          rvalidport;
    logic                     m_ready;

    logic                     outread, m_last, m_valid, busy;
    logic [DW-1:0]            m_data;
    logic [IDXW-1:0]          m_row;
    logic [15:0]              results_total;

    logic                     w_outread, w_m_last, w_m_valid, w_busy;
    logic [DW-1:0]            w_m_data;
    logic [IDXW-1:0]          w_m_row;
    logic [3:0]               w_results_total;

    sa_result_drain #(.ROWS(ROWS), .DW(DW), .CNTW(16)) dut (
        .clk(clk), .rstn(rstn), .routport(routport), .rvalidport(rvalidport),
        .outread(outread), .m_data(m_data), .m_row(m_row), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
        .results_total(results_total)
    );

    sa_result_drain #(.ROWS(ROWS), .DW(DW), .CNTW(4)) dut_w (
        .clk(clk), .rstn(rstn), .routport(routport), .rvalidport(rvalidport),
        .outread(w_outread), .m_data(w_m_data), .m_row(w_m_row), .m_last(w_m_last),
        .m_valid(w_m_valid), .m_ready(m_ready), .busy(w_busy),
        .results_total(w_results_total)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int total_model = 0;
    logic [ROWS-1:0][DW-1:0] cur_data;
    logic [ROWS-1:0][DW-1:0] next_data;
    logic [ROWS-1:0]         next_mask;
    bit                      aborted;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_outread"}, outread, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"},  m_data, 0);
        chk({tag, "_m_row"},   m_row, 0);
        chk({tag, "_m_last"},  m_last, 0);
        chk({tag, "_busy"},    busy, 0);
        chk({tag, "_total"},   results_total, 0);
        chk({tag, "_total_w"}, w_results_total, 0);
    endtask

    // Hold reset a couple of cycles, release, and confirm the block stays
    // quiet while the core presents nothing.
    task automatic release_reset();
        rvalidport = '0;
        step();
        step();
        rstn = 1'b1;
        total_model = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_reset_outread", outread, 0);
            chk("post_reset_busy", busy, 0);
        end
    endtask

    // One snapshot, starting at the sample point of an IDLE cycle (cycle 0).
    // mode: 0 = ready always, 1 = ready pattern 1,0,0,..., 2 = random ready.
    task automatic snapshot(input logic [ROWS-1:0] mask, input int mode,
                            input bit perturb, input bit chain, input bit drive,
                            input int abort_after, output bit was_aborted);
        int            exp_row[$];
        logic [DW-1:0] exp_dat[$];
        int            cyc, stalls, accepted, n;
        bit            rdy;

        was_aborted = 1'b0;
        if (drive) begin
            routport   = cur_data;
            rvalidport = mask;
        end
        for (int i = 0; i < ROWS; i++) begin
            if (mask[i]) begin
                exp_row.push_back(i);
                exp_dat.push_back(cur_data[i]);
            end
        end
        n = exp_row.size();
        chk("idle_outread", outread, 0);
        chk("idle_busy", busy, 0);

        step();
        cyc = 1;
        chk("ack_outread", outread, 1);
        chk("ack_m_valid", m_valid, 0);
        chk("ack_busy", busy, 1);
        rvalidport = '0;
        if (perturb) routport[0] = '1;

        stalls   = 0;
        accepted = 0;
        while (1) begin
            step();
            cyc++;
            if (cyc > 300) begin
                checks++;
                errors++;
                $error("FAIL drain_timeout: observed cycle %0d expected end by %0d", cyc, 2 + n + stalls);
                break;
            end
            if (abort_after >= 0 && accepted == abort_after) begin
                rstn = 1'b0;
                #1;
                check_reset_outputs("mid_drain_reset");
                total_model = 0;
                was_aborted = 1'b1;
                break;
            end
            if (chain && cyc == 3) begin
                rvalidport = next_mask;
                routport   = next_data;
            end
            chk("results_total", results_total, 64'(total_model & 16'hFFFF));
            chk("results_total_w", w_results_total, 64'(total_model & 4'hF));
            chk("drain_outread", outread, 0);
            if (exp_row.size() == 0) begin
                chk("idle_cycle", cyc, 2 + n + stalls);
                chk("end_m_valid", m_valid, 0);
                chk("end_busy", busy, 0);
                break;
            end
            chk("beat_valid", m_valid, 1);
            chk("beat_row", m_row, exp_row[0]);
            chk("beat_data", m_data, exp_dat[0]);
            chk("beat_last", m_last, (exp_row.size() == 1));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (((cyc - 2) % 3) == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            m_ready = rdy;
            if (rdy) begin
                $display("beat row=%0d data=%08h last=%0d cyc=%0d", exp_row[0], exp_dat[0], exp_row.size() == 1, cyc);
                void'(exp_row.pop_front());
                void'(exp_dat.pop_front());
                total_model++;
                accepted++;
            end else begin
                stalls++;
            end
        end
    endtask

    initial begin
        rstn       = 1'b0;
        routport   = '0;
        rvalidport = '0;
        m_ready    = 1'b0;
        cur_data   = '0;
        next_data  = '0;
        next_mask  = '0;
        #2;
        check_reset_outputs("reset");
        release_reset();

        // Reset during a full drain after three accepted beats.
        for (int i = 0; i < ROWS; i++) cur_data[i] = $urandom();
        snapshot(8'hFF, 0, 1'b0, 1'b0, 1'b1, 3, aborted);
        chk("abort_taken", aborted, 1);
        release_reset();

        // Full snapshot with incrementing data.
        for (int i = 0; i < ROWS; i++) cur_data[i] = 32'h100 + i;
        snapshot(8'hFF, 0, 1'b0, 1'b0, 1'b1, -1, aborted);
        chk("full_total", results_total, 8);

        // Sparse mask: rows 2 and 7 only.
        for (int i = 0; i < ROWS; i++) cur_data[i] = $urandom();
        cur_data[2] = 32'hDEAD_BEEF;
        cur_data[7] = 32'h0000_0007;
        snapshot(8'b1000_0100, 0, 1'b0, 1'b0, 1'b1, -1, aborted);

        // Backpressure pattern 1,0,0 on a full snapshot.
        for (int i = 0; i < ROWS; i++) cur_data[i] = $urandom();
        snapshot(8'hFF, 1, 1'b0, 1'b0, 1'b1, -1, aborted);

        // Capture isolation plus a second snapshot raised mid-drain.
        for (int i = 0; i < ROWS; i++) begin
            cur_data[i]  = $urandom();
            next_data[i] = $urandom();
        end
        next_mask = ROWS'($urandom_range(1, 255));
        snapshot(8'hFF, 0, 1'b1, 1'b1, 1'b1, -1, aborted);
        cur_data = next_data;
        snapshot(next_mask, 2, 1'b0, 1'b0, 1'b0, -1, aborted);

        // Randomised snapshots.
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < ROWS; i++) cur_data[i] = $urandom();
            snapshot(ROWS'($urandom_range(1, 255)), int'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)), 1'b0, 1'b1, -1, aborted);
        end

        // Counter wrap: 24 beats from reset on the 4-bit instance.
        rstn = 1'b0;
        #1;
        check_reset_outputs("wrap_reset");
        release_reset();
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < ROWS; i++) cur_data[i] = $urandom();
            snapshot(8'hFF, 0, 1'b0, 1'b0, 1'b1, -1, aborted);
        end
        chk("wrap_cnt4", w_results_total, 8);
        chk("cnt16_24", results_total, 24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_result_drain.md
Name: sa_result_drain

Overview:
- Consumer end of the systolic core's result interface.
- Watches the per-row result valids (rvalidport) and snapshots the per-row 32-bit results (routport).
- Acknowledges each snapshot to the core with a one-cycle outread pulse.
- Serialises the valid rows, lowest row first, onto a single valid/ready stream for the downstream writeback/host path.

Parameters:
ROWS, 8, number of systolic rows (one result lane each)
DW, 32, result width per row
CNTW, 16, width of the accepted-results counter

Ports:
clk  input  1  clock; all logic on rising edge
rstn  input  1  reset, asynchronous, active-low
routport  input  ROWS x DW  per-row results from the core
rvalidport  input  ROWS  per-row result valid from the core; bit i refers to row i
outread  output  1  one-cycle acknowledge to the core
m_data  output  DW  serialised result
m_row  output  $clog2(ROWS)  row index of m_data
m_last  output  1  final beat of the current snapshot
m_valid  output  1  stream valid
m_ready  input  1  stream ready
busy  output  1  high in any state other than IDLE
results_total  output  CNTW  count of accepted beats; wraps at 2^CNTW

Behaviour:
- Core protocol (fixed):
  - Core holds rvalidport and routport stable until it samples outread=1.
  - Core clears the acknowledged valid bits on the following cycle.
  - Core does not re-assert valid earlier than 2 cycles after the outread cycle.
- Reset (async, rstn=0):
  - State=IDLE; snapshot data and mask cleared.
  - outread=0, m_valid=0, m_last=0, m_data=0, m_row=0, busy=0, results_total=0.
  - Takes effect immediately, including mid-DRAIN; beats not yet accepted are discarded. No outread is issued during or right after reset.
- IDLE:
  - If rvalidport != 0: latch all ROWS of routport into the snapshot regs and rvalidport into mask; go to ACK.
  - Otherwise remain in IDLE.
- ACK (exactly 1 cycle): outread=1; go to DRAIN. outread is 0 in every other state.
- DRAIN:
  - m_valid=1.
  - m_row = index of the lowest set bit of mask; m_data = snapshot[m_row].
  - m_last=1 when mask has exactly one bit set.
  - On m_valid&&m_ready: clear that mask bit and increment results_total.
  - If the accepted beat was m_last, go to IDLE next cycle.
- Latency:
  - Valid observed in cycle 0; outread in cycle 1; first beat presented in cycle 2.
  - With m_ready held high, N set rows drain in cycles 2..N+1; IDLE re-samples in cycle N+2.
- Stall: while m_ready=0, m_data, m_row and m_last hold stable and m_valid stays 1 (AXI-style, no retraction).
- Values are captured at the IDLE cycle only. Changes on routport/rvalidport during ACK or DRAIN are ignored.
- Sparse mask (e.g. 8'b1000_0001): only set rows are emitted, in ascending index order. Zero bits cost no cycles.
- Full mask: ROWS beats; m_last on row ROWS-1.
- results_total wraps from 2^CNTW-1 to 0 with no flag.
- Back-to-back snapshots: minimum 1 IDLE cycle between consecutive DRAINs. No snapshot is lost, because the core holds valid until acknowledged.

Decomposition:
- Shared package sa_pkg, which the core and feeder also use:
  - ROWS, DW.
  - typedef result_t (logic [DW-1:0]).
  - typedef row_idx_t (logic [$clog2(ROWS)-1:0]).
  - typedef row_mask_t (logic [ROWS-1:0]).
  - enum drain_state_t {IDLE, ACK, DRAIN}.
- Sub-module sa_lsb_enc: combinational lowest-set-bit encoder. Inputs: row_mask_t. Outputs: row_idx_t index, onehot flag, any flag. Reused by m_row and m_last generation.

Test Plan:
- Reset mid-DRAIN: rvalidport=8'hFF, drop rstn after 3 accepted beats -> outputs zero immediately, results_total=0, no outread after release while rvalidport=0.
- Full snapshot: rvalidport=8'hFF, routport[i]=32'h100+i, m_ready=1 -> outread pulse in cycle 1 only; beats in cycles 2..9 with m_row 0..7, m_data 0x100..0x107; m_last only on row 7; results_total=8.
- Sparse: rvalidport=8'b1000_0100, routport[2]=32'hDEAD_BEEF, routport[7]=32'h0000_0007 -> exactly 2 beats (row 2 then row 7), m_last on row 7, state back to IDLE in cycle 4.
- Backpressure: full snapshot, m_ready toggles 1,0,0,1,... -> data/row stable during stalls, no duplicated or skipped rows, 8 beats total, single outread pulse.
- Capture isolation: during DRAIN change routport[0] to 32'hFFFF_FFFF -> emitted row-0 value is the captured one. Second snapshot 2 cycles after outread is captured after DRAIN ends and drains correctly.
- Counter wrap: CNTW=4, 3 full snapshots (24 beats) -> results_total=8.
